// File: rtl/mod_m_updown_counter.sv
// Modulo-M up/down counter with enable, clamped synchronous load, wrap/saturate mode,
// registered wrap tick and sticky overflow. Optional enable prescaler: COUNTER_PRESCALE_EN.
module mod_m_updown_counter #(
  parameter int N            = 4,
  parameter int M            = 10,
  parameter int PRESCALE_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up_down,
  input  logic         sat,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count,
  output logic         complete_tick,
  output logic         at_max,
  output logic         at_zero,
  output logic         ovf
);

  localparam logic [N-1:0] MAX_C = N'(M - 1);

  if (M < 2 || M > (2 ** N) || PRESCALE_DIV < 2) begin : g_bad_params
    $error("mod_m_updown_counter: illegal N/M/PRESCALE_DIV combination");
  end

  logic         prescale_hit;
  logic         step;
  logic [N-1:0] count_q, count_d;
  logic         tick_q, tick_d;
  logic         ovf_q, ovf_d;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE_DIV - 1);

  logic [PW-1:0] ps_q, ps_d;

  assign prescale_hit = (ps_q == PS_LAST);

  // Prescaler only advances on enabled cycles; a load restarts the ratio.
  always_comb begin
    ps_d = ps_q;
    if (load) begin
      ps_d = '0;
    end else if (en) begin
      ps_d = prescale_hit ? '0 : ps_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  assign prescale_hit = 1'b1;
`endif

  assign step = en & prescale_hit;

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    ovf_d   = ovf_q;
    if (load) begin
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
      ovf_d   = 1'b0;
    end else if (step) begin
      if (up_down) begin
        if (count_q != MAX_C) begin
          count_d = count_q + N'(1);
        end else if (sat) begin
          ovf_d = 1'b1;
        end else begin
          count_d = '0;
          tick_d  = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - N'(1);
        end else if (sat) begin
          ovf_d = 1'b1;
        end else begin
          count_d = MAX_C;
          tick_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count         = count_q;
  assign complete_tick = tick_q;
  assign ovf           = ovf_q;
  assign at_max        = (count_q == MAX_C);
  assign at_zero       = (count_q == '0);

endmodule

// File: tb/tb_mod_m_updown_counter.sv
// Directed bench for mod_m_updown_counter (N=4, M=10); prescaler scenario runs
// instead of the main sequence when COUNTER_PRESCALE_EN is defined.
module tb_mod_m_updown_counter;

  localparam int N = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         en, up_down, sat, load;
  logic [N-1:0] load_val;
  logic [N-1:0] count;
  logic         complete_tick, at_max, at_zero, ovf;

  int checks = 0;
  int errors = 0;

  mod_m_updown_counter #(.N(N), .M(M), .PRESCALE_DIV(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .up_down       (up_down),
    .sat           (sat),
    .load          (load),
    .load_val      (load_val),
    .count         (count),
    .complete_tick (complete_tick),
    .at_max        (at_max),
    .at_zero       (at_zero),
    .ovf           (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_val = N'(v); en = 1'b0;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up_down = 1'b1; sat = 1'b0; load = 1'b0; load_val = '0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_at_zero", at_zero, 1);
    chk("rst_at_max", at_max, 0);
    chk("rst_tick", complete_tick, 0);
    chk("rst_ovf", ovf, 0);
    cyc(); cyc();
    reset = 1'b0;

`ifndef COUNTER_PRESCALE_EN
    // Wrap up: 0..9,0,1 with tick only when count returns to 0.
    en = 1'b1; up_down = 1'b1; sat = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk($sformatf("up_count_%0d", i), count, i % 10);
      chk($sformatf("up_tick_%0d", i), complete_tick, (i == 10) ? 1 : 0);
      chk($sformatf("up_at_max_%0d", i), at_max, ((i % 10) == 9) ? 1 : 0);
    end
    en = 1'b0;

    // Wrap down from 0.
    do_load(0);
    chk("dn_pre_count", count, 0);
    chk("dn_pre_at_zero", at_zero, 1);
    en = 1'b1; up_down = 1'b0;
    cyc();
    chk("dn_count_9", count, 9);
    chk("dn_tick_9", complete_tick, 1);
    chk("dn_at_max_9", at_max, 1);
    chk("dn_at_zero_9", at_zero, 0);
    cyc();
    chk("dn_count_8", count, 8);
    chk("dn_tick_8", complete_tick, 0);
    en = 1'b0;

    // Saturate up from 8.
    do_load(8);
    chk("sat_load_count", count, 8);
    en = 1'b1; up_down = 1'b1; sat = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk($sformatf("sat_count_%0d", i), count, 9);
      chk($sformatf("sat_ovf_%0d", i), ovf, (i >= 2) ? 1 : 0);
      chk($sformatf("sat_tick_%0d", i), complete_tick, 0);
    end
    up_down = 1'b0;
    cyc();
    chk("sat_back_count", count, 8);
    chk("sat_back_ovf_sticky", ovf, 1);
    do_load(3);
    chk("sat_reload_count", count, 3);
    chk("sat_reload_ovf", ovf, 0);

    // Load priority and clamp: en and up_down ignored while loading 15.
    load = 1'b1; load_val = 4'd15; en = 1'b1; up_down = 1'b1; sat = 1'b0;
    cyc();
    chk("clamp_count", count, 9);
    chk("clamp_tick", complete_tick, 0);
    chk("clamp_at_max", at_max, 1);
    load = 1'b0; en = 1'b0;

    // Async reset mid-count at 6.
    do_load(5);
    en = 1'b1; up_down = 1'b1; sat = 1'b0;
    cyc();
    chk("ar6_pre_count", count, 6);
    en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar6_count", count, 0);
    chk("ar6_at_zero", at_zero, 1);
    #1 reset = 1'b0;

    // Async reset with tick and ovf both set.
    do_load(9);
    en = 1'b1; up_down = 1'b1; sat = 1'b1;
    cyc();
    chk("ar_pre_ovf", ovf, 1);
    sat = 1'b0;
    cyc();
    chk("ar_pre_count", count, 0);
    chk("ar_pre_tick", complete_tick, 1);
    chk("ar_pre_ovf2", ovf, 1);
    en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_count", count, 0);
    chk("ar_tick", complete_tick, 0);
    chk("ar_ovf", ovf, 0);
    #1 reset = 1'b0;
    cyc();
`else
    // Prescaler: one step per four enabled cycles.
    en = 1'b1; up_down = 1'b1; sat = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk($sformatf("ps_count_%0d", i), count, i / 4);
    end
    en = 1'b0;
    cyc(); cyc();
    chk("ps_gap_count", count, 4);
    en = 1'b1;
    cyc(); cyc(); cyc();
    chk("ps_after_gap_3", count, 4);
    cyc();
    chk("ps_after_gap_4", count, 5);
    en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
